// File: rtl/sign_extend_immediate_pkg.sv
// Shared datapath widths and the immediate sign-extension helper.
// Decode and ALU blocks import the same package.
package sign_extend_immediate_pkg;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

    typedef logic [IMM_W-1:0]  imm_t;
    typedef logic [DATA_W-1:0] data_t;

    // Replicate the immediate's top bit across the upper data bits.
    function automatic data_t sext(input imm_t imm);
        sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/sign_extend_immediate.sv
// Registered sign extension of an IN_W-bit immediate to OUT_W bits.
// The output changes only on the rising clock edge, and it loads on every edge.
module sign_extend_immediate
    import sign_extend_immediate_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  instruction,
    output logic [OUT_W-1:0] sign_extended_imm
);

    if (OUT_W < IN_W) begin : g_width_check
        $error("sign_extend_immediate: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
    end

    logic [OUT_W-1:0] ext_next;
    logic [OUT_W-1:0] ext_reg;

    // At the package widths, use the shared helper so that every block extends identically.
    if (IN_W == IMM_W && OUT_W == DATA_W) begin : g_pkg_ext
        assign ext_next = sext(instruction);
    end else begin : g_generic_ext
        always_comb begin
            ext_next             = {OUT_W{instruction[IN_W-1]}};
            ext_next[IN_W-1:0]   = instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_reg <= '0;
        end else begin
            ext_reg <= ext_next;
        end
    end

    assign sign_extended_imm = ext_reg;

endmodule

// File: tb/tb_sign_extend_immediate.sv
// Directed test bench for sign_extend_immediate. A per-cycle arithmetic model
// is checked against the DUT, alongside directed checks against literal expected values.
module tb_sign_extend_immediate;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic [31:0] dout;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_exp = 32'h0;
    logic        model_valid = 1'b0;

    sign_extend_immediate dut (
        .clk              (clk),
        .reset            (reset),
        .instruction      (instruction),
        .sign_extended_imm(dout)
    );

    always #5 clk = ~clk;

    // Interpret the immediate as a two's-complement integer, then take it as 32 bits.
    function automatic logic [31:0] model_ext(input logic [15:0] v);
        int s;
        s = int'(v);
        if (s >= 32768) s = s - 65536;
        return 32'(s);
    endfunction

    always @(posedge clk) begin
        model_exp   <= reset ? 32'h0 : model_ext(instruction);
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (dout !== model_exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%h want=%h", $time, dout, model_exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("ok   %s value=%h", name, got);
        end
    endtask

    task automatic step(input string name, input logic r, input logic [15:0] i,
                        input logic [31:0] want);
        reset       = r;
        instruction = i;
        @(posedge clk);
        #1;
        check(name, dout, want);
    endtask

    initial begin
        // Tie the model itself to hand-computed literal values.
        check("model_7fff", model_ext(16'h7FFF), 32'h00007FFF);
        check("model_8000", model_ext(16'h8000), 32'hFFFF8000);
        check("model_ffff", model_ext(16'hFFFF), 32'hFFFFFFFF);

        // Reset pulse train: high, low, high, then low.
        step("rst_pulse1", 1'b1, 16'hABCD, 32'h00000000);
        step("rst_gap",    1'b0, 16'h0000, 32'h00000000);
        step("rst_pulse2", 1'b1, 16'h5555, 32'h00000000);

        step("pos_1234",   1'b0, 16'h1234, 32'h00001234);
        step("pos_7fff",   1'b0, 16'h7FFF, 32'h00007FFF);
        step("neg_ffff",   1'b0, 16'hFFFF, 32'hFFFFFFFF);
        step("neg_8a12",   1'b0, 16'h8A12, 32'hFFFF8A12);
        step("neg_8000",   1'b0, 16'h8000, 32'hFFFF8000);
        step("zero",       1'b0, 16'h0000, 32'h00000000);

        // Latency: changing the input between edges must not reach the output.
        step("lat_load",   1'b0, 16'h1234, 32'h00001234);
        instruction = 16'h8000;
        #3;
        check("lat_hold", dout, 32'h00001234);
        @(posedge clk);
        #1;
        check("lat_next", dout, 32'hFFFF8000);

        // Reset priority over a negative load, then release.
        step("prio_rst_a", 1'b1, 16'hFFFF, 32'h00000000);
        step("prio_rst_b", 1'b1, 16'hFFFF, 32'h00000000);
        step("prio_rel",   1'b0, 16'hFFFF, 32'hFFFFFFFF);

        // Mid-stream reset followed by an immediate reload.
        step("mid_load",   1'b0, 16'h4321, 32'h00004321);
        step("mid_rst",    1'b1, 16'h4321, 32'h00000000);
        step("mid_reload", 1'b0, 16'h0001, 32'h00000001);

        // Random traffic, checked only by the per-cycle model comparison.
        for (int k = 0; k < 60; k++) begin
            reset       = ($urandom_range(0, 15) == 0);
            instruction = 16'($urandom);
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
